// File: rtl/mcpu_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing with a bounded memory wait.
// Define MCPU_CTRL_PERF_EN to add the instret and cycle_cnt performance counters.
module mcpu_ctrl #(
    parameter int ALU_W       = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       OPcode,
    input  logic [2:0]       Fun3,
    input  logic [11:0]      Fun12,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic [2:0]       state,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [ALU_W-1:0] alu_control,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             trap,
    output logic [1:0]       trap_cause
`ifdef MCPU_CTRL_PERF_EN
    ,
    output logic [31:0]      instret,
    output logic [31:0]      cycle_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR,
        C_LUI, C_AUIPC, C_ILL, C_ENV, C_MRET
    } cls_t;

    // ALU encoding: {is_compare, funct7[5], funct3}; compare ops carry the branch funct3.
    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    cls_t       cls_q, dec_cls;
    logic [4:0] op_q, dec_op, alu_op;
    logic [1:0] cause_q, cause_d;
    logic [7:0] wait_cnt;
    logic [6:0] f7;
    logic       timeout;

    assign f7          = Fun12[11:5];
    assign timeout     = !mem_ready && (wait_cnt == WAIT_LAST);
    assign state       = state_q;
    assign alu_control = ALU_W'(alu_op);

    always_comb begin
        dec_cls = C_ILL;
        dec_op  = ALU_ADD;
        case (OPcode)
            7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (Fun3 == 3'b000 || Fun3 == 3'b101))) begin
                dec_cls = C_R;
                dec_op  = {1'b0, f7[5], Fun3};
            end
            7'b0010011: if ((Fun3 == 3'b001 && f7 == 7'h00) ||
                            (Fun3 == 3'b101 && (f7 == 7'h00 || f7 == 7'h20)) ||
                            (Fun3 != 3'b001 && Fun3 != 3'b101)) begin
                dec_cls = C_IALU;
                dec_op  = {1'b0, f7[5] & (Fun3 == 3'b101), Fun3};
            end
            7'b0000011: if (Fun3 != 3'b011 && Fun3 != 3'b110 && Fun3 != 3'b111) dec_cls = C_LOAD;
            7'b0100011: if (Fun3 <= 3'b010) dec_cls = C_STORE;
            7'b1100011: if (Fun3 != 3'b010 && Fun3 != 3'b011) begin
                dec_cls = C_BRANCH;
                dec_op  = {2'b10, Fun3};
            end
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: if (Fun3 == 3'b000) dec_cls = C_JALR;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            7'b1110011: if (Fun3 == 3'b000) begin
                if (Fun12 == 12'h000 || Fun12 == 12'h001) dec_cls = C_ENV;
                else if (Fun12 == 12'h302)                dec_cls = C_MRET;
            end
            default: dec_cls = C_ILL;
        endcase
    end

    // Handshake: mem_req stays high in FETCH/MEM until a cycle with mem_ready=1 completes the
    // transfer or the wait counter expires; mem_ready seen in any other state is ignored.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 2'd0;
        trap       = 1'b0;
        trap_cause = 2'd0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timeout) begin
                        cause_d = 2'd2;
                        state_d = S_TRAP;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'd1;
                    case (dec_cls)
                        C_ILL:   begin cause_d = 2'd0; state_d = S_TRAP; end
                        C_ENV:   begin cause_d = 2'd1; state_d = S_TRAP; end
                        C_MRET:  begin cause_d = 2'd3; state_d = S_TRAP; end
                        default: state_d = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    case (cls_q)
                        C_R: begin
                            alu_src_a = 2'd1;
                            alu_op    = op_q;
                            state_d   = S_WB;
                        end
                        C_IALU: begin
                            alu_src_a = 2'd1;
                            alu_src_b = 2'd1;
                            alu_op    = op_q;
                            state_d   = S_WB;
                        end
                        C_LOAD, C_STORE: begin
                            alu_src_a = 2'd1;
                            alu_src_b = 2'd1;
                            state_d   = S_MEM;
                        end
                        C_BRANCH: begin
                            alu_src_a = 2'd1;
                            alu_op    = op_q;
                            pc_write  = br_taken;
                            pc_src    = 2'd1;
                        end
                        C_JAL: begin
                            pc_write   = 1'b1;
                            pc_src     = 2'd1;
                            reg_write  = 1'b1;
                            mem_to_reg = 2'd2;
                        end
                        C_JALR: begin
                            alu_src_a  = 2'd1;
                            alu_src_b  = 2'd1;
                            pc_write   = 1'b1;
                            pc_src     = 2'd1;
                            reg_write  = 1'b1;
                            mem_to_reg = 2'd2;
                        end
                        C_LUI: begin
                            reg_write  = 1'b1;
                            mem_to_reg = 2'd3;
                        end
                        C_AUIPC: begin
                            alu_src_b = 2'd1;
                            state_d   = S_WB;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (cls_q == C_STORE);
                    if (mem_ready) begin
                        state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
                    end else if (timeout) begin
                        cause_d = 2'd2;
                        state_d = S_TRAP;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (cls_q == C_LOAD) ? 2'd1 : 2'd0;
                    state_d    = S_FETCH;
                end
                S_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                    pc_write   = 1'b1;
                    pc_src     = (cause_q == 2'd3) ? 2'd3 : 2'd2;
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            cls_q    <= C_ILL;
            op_q     <= ALU_ADD;
            cause_q  <= 2'd0;
            wait_cnt <= 8'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_d != state_q)          wait_cnt <= 8'd0;
            else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
            if (state_q == S_DECODE) begin
                cls_q <= dec_cls;
                op_q  <= dec_op;
            end
        end
    end

`ifdef MCPU_CTRL_PERF_EN
    // Retirement is any non-trap return to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret   <= 32'd0;
            cycle_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (state_d == S_FETCH &&
                (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
                instret <= instret + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Bench for mcpu_ctrl: per-instruction expected cycle traces built from the instruction class,
// with randomized instructions, memory latencies and branch outcomes.
module tb_mcpu_ctrl;

    localparam int TO = 15;
    localparam int OW = 25;
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_JALR = 6,
                   K_LUI = 7, K_AUIPC = 8, K_ILL = 9, K_ENV = 10, K_MRET = 11;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [4:0] alu;
        logic       rw;
        logic [1:0] m2r;
        logic       trap;
        logic [1:0] cause;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  OPcode;
    logic [2:0]  Fun3;
    logic [11:0] Fun12;
    logic        mem_ready;
    logic        br_taken;
    logic [2:0]  state;
    logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write, trap;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, mem_to_reg, trap_cause;
    logic [4:0]  alu_control;
`ifdef MCPU_CTRL_PERF_EN
    logic [31:0] instret, cycle_cnt, tb_cycles;
`endif

    out_t          obs;
    logic [OW-1:0] exp_q[$];
    logic [1:0]    drv_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_instret = 32'd0;

    assign obs = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_control, reg_write, mem_to_reg, trap, trap_cause};

    mcpu_ctrl #(.ALU_W(5), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun3(Fun3), .Fun12(Fun12),
        .mem_ready(mem_ready), .br_taken(br_taken), .state(state), .mem_req(mem_req),
        .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .trap(trap), .trap_cause(trap_cause)
`ifdef MCPU_CTRL_PERF_EN
        , .instret(instret), .cycle_cnt(cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

`ifdef MCPU_CTRL_PERF_EN
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cycles <= 32'd0;
        else        tb_cycles <= tb_cycles + 32'd1;
    end
`endif

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, x);
        end
    endtask

    function automatic logic rndbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic out_t blank(input logic [2:0] st);
        out_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic int classify(input logic [31:0] ir);
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] f12;
        f3  = ir[14:12];
        f7  = ir[31:25];
        f12 = ir[31:20];
        case (ir[6:0])
            7'h33: return (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) ? K_R : K_ILL;
            7'h13: begin
                if (f3 == 1) return (f7 == 0) ? K_I : K_ILL;
                if (f3 == 5) return (f7 == 0 || f7 == 7'h20) ? K_I : K_ILL;
                return K_I;
            end
            7'h03: return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) ? K_LD : K_ILL;
            7'h23: return (f3 <= 2) ? K_ST : K_ILL;
            7'h63: return (f3 == 2 || f3 == 3) ? K_ILL : K_BR;
            7'h6F: return K_JAL;
            7'h67: return (f3 == 0) ? K_JALR : K_ILL;
            7'h37: return K_LUI;
            7'h17: return K_AUIPC;
            7'h73: begin
                if (f3 == 0 && (f12 == 0 || f12 == 1)) return K_ENV;
                if (f3 == 0 && f12 == 12'h302)         return K_MRET;
                return K_ILL;
            end
            default: return K_ILL;
        endcase
    endfunction

    task automatic push(input out_t e, input logic rdy, input logic br);
        exp_q.push_back(e);
        drv_q.push_back({rdy, br});
    endtask

    task automatic push_trap(input logic [1:0] cause);
        out_t e;
        e          = blank(3'd5);
        e.trap     = 1'b1;
        e.pc_write = 1'b1;
        e.pc_src   = (cause == 2'd3) ? 2'd3 : 2'd2;
        e.cause    = cause;
        push(e, rndbit(), rndbit());
    endtask

    task automatic mem_phase(input logic is_st, input int lat, output logic ok);
        out_t e;
        for (int k = 0; k < TO && k <= lat; k++) begin
            e         = blank(3'd3);
            e.mem_req = 1'b1;
            e.iord    = 1'b1;
            e.mem_we  = is_st;
            push(e, k == lat, rndbit());
        end
        ok = (lat < TO);
        if (!ok) push_trap(2'd2);
    endtask

    // Expected cycle-by-cycle trace of one instruction, including the memory-ready drive.
    task automatic build(input logic [31:0] ir, input int flat, input int mlat, input logic br,
                         output logic retire);
        out_t       e;
        int         cls;
        logic       ok;
        logic [2:0] f3;
        logic [6:0] f7;
        f3     = ir[14:12];
        f7     = ir[31:25];
        cls    = classify(ir);
        retire = 1'b0;
        for (int k = 0; k < TO && k <= flat; k++) begin
            e         = blank(3'd0);
            e.mem_req = 1'b1;
            if (k == flat) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
            end
            push(e, k == flat, rndbit());
        end
        if (flat >= TO) begin
            push_trap(2'd2);
            return;
        end
        e   = blank(3'd1);
        e.b = 2'd1;
        push(e, rndbit(), rndbit());
        if (cls == K_ILL)  begin push_trap(2'd0); return; end
        if (cls == K_ENV)  begin push_trap(2'd1); return; end
        if (cls == K_MRET) begin push_trap(2'd3); return; end
        e = blank(3'd2);
        case (cls)
            K_R:         begin e.a = 2'd1; e.alu = {1'b0, f7[5], f3}; end
            K_I:         begin e.a = 2'd1; e.b = 2'd1; e.alu = {1'b0, (f3 == 3'd5) & f7[5], f3}; end
            K_LD, K_ST:  begin e.a = 2'd1; e.b = 2'd1; end
            K_BR:        begin e.a = 2'd1; e.alu = {2'b10, f3}; e.pc_write = br; e.pc_src = 2'd1; end
            K_JAL:       begin e.pc_write = 1'b1; e.pc_src = 2'd1; e.rw = 1'b1; e.m2r = 2'd2; end
            K_JALR:      begin
                e.a = 2'd1; e.b = 2'd1; e.pc_write = 1'b1; e.pc_src = 2'd1; e.rw = 1'b1; e.m2r = 2'd2;
            end
            K_LUI:       begin e.rw = 1'b1; e.m2r = 2'd3; end
            default:     e.b = 2'd1;
        endcase
        push(e, rndbit(), br);
        if (cls == K_LD || cls == K_ST) begin
            mem_phase(cls == K_ST, mlat, ok);
            if (!ok) return;
        end
        if (cls == K_R || cls == K_I || cls == K_AUIPC || cls == K_LD) begin
            e     = blank(3'd4);
            e.rw  = 1'b1;
            e.m2r = (cls == K_LD) ? 2'd1 : 2'd0;
            push(e, rndbit(), rndbit());
        end
        retire = 1'b1;
    endtask

    task automatic run_n(input string tag, input int n);
        logic [1:0] d;
        out_t       e;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            d         = drv_q.pop_front();
            e         = exp_q.pop_front();
            mem_ready = d[1];
            br_taken  = d[0];
            @(negedge clk);
            check($sformatf("%s st%0d", tag, e.st), 32'(obs), 32'(e));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ir(input logic [31:0] ir);
        OPcode = ir[6:0];
        Fun3   = ir[14:12];
        Fun12  = ir[31:20];
    endtask

    task automatic do_instr(input string tag, input logic [31:0] ir, input int flat,
                            input int mlat, input logic br);
        logic retire;
        set_ir(ir);
        build(ir, flat, mlat, br, retire);
        run_n(tag, exp_q.size());
        if (retire) exp_instret++;
`ifdef MCPU_CTRL_PERF_EN
        @(negedge clk);
        check({tag, " instret"}, instret, exp_instret);
        check({tag, " cycle_cnt"}, cycle_cnt, tb_cycles);
        @(posedge clk);
        #1;
`endif
    endtask

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 19);
        if (r < 14) return r % 4;
        if (r < 16) return TO - 1;
        if (r < 18) return TO;
        return TO + 10;
    endfunction

    initial begin
        out_t e;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        br_taken  = 1'b1;
        set_ir(32'h002081B3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", 32'(obs), 32'h0);
`ifdef MCPU_CTRL_PERF_EN
        check("reset instret", instret, 32'h0);
        check("reset cycle_cnt", cycle_cnt, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_instr("add", 32'h002081B3, 1, 0, 1'b0);
        do_instr("lw", 32'h0000A183, 0, 3, 1'b0);
        do_instr("beq_t", 32'h00208063, 0, 0, 1'b1);
        do_instr("beq_nt", 32'h00208063, 2, 0, 1'b0);
        do_instr("fetch_to", 32'h00000013, TO + 5, 0, 1'b0);
        do_instr("fetch_last", 32'h00000013, TO - 1, 0, 1'b0);
        do_instr("ir_zero", 32'h00000000, 0, 0, 1'b0);
        do_instr("ecall", 32'h00000073, 0, 0, 1'b0);
        do_instr("ebreak", 32'h00100073, 0, 0, 1'b0);
        do_instr("mret", 32'h30200073, 0, 0, 1'b0);
        do_instr("fence", 32'h0000000F, 0, 0, 1'b0);
        do_instr("sw", 32'h0020A023, 1, 2, 1'b0);
        do_instr("sw_to", 32'h0020A023, 0, TO + 3, 1'b0);
        do_instr("lw_last", 32'h0000A183, 0, TO - 1, 1'b0);
        do_instr("jal", 32'h008000EF, 0, 0, 1'b1);
        do_instr("jalr", 32'h000080E7, 0, 0, 1'b0);
        do_instr("lui", 32'h000011B7, 0, 0, 1'b0);
        do_instr("auipc", 32'h00001197, 0, 0, 1'b0);
        do_instr("sub", 32'h402081B3, 0, 0, 1'b0);
        do_instr("srai", 32'h4020D193, 0, 0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] ir;
            int          sel;
            ir  = $urandom();
            sel = $urandom_range(0, 11);
            case (sel)
                0, 10: ir[6:0] = 7'h33;
                1:     ir[6:0] = 7'h13;
                2:     ir[6:0] = 7'h03;
                3:     ir[6:0] = 7'h23;
                4:     ir[6:0] = 7'h63;
                5:     ir[6:0] = 7'h6F;
                6:     ir[6:0] = 7'h67;
                7:     ir[6:0] = 7'h37;
                8:     ir[6:0] = 7'h17;
                9: begin
                    case ($urandom_range(0, 3))
                        0:       ir = 32'h00000073;
                        1:       ir = 32'h00100073;
                        2:       ir = 32'h30200073;
                        default: ir[6:0] = 7'h73;
                    endcase
                end
                default: ;
            endcase
            if ((sel == 0 || sel == 1 || sel == 10) && $urandom_range(0, 3) != 0)
                ir[31:25] = rndbit() ? 7'h20 : 7'h00;
            do_instr("rand", ir, pick_lat(), pick_lat(), rndbit());
        end

        // Reset asserted while a load waits in MEM.
        set_ir(32'h0000A183);
        begin
            logic retire;
            build(32'h0000A183, 0, TO + 10, 1'b0, retire);
        end
        run_n("rst_pre", 5);
        exp_q.delete();
        drv_q.delete();
        mem_ready = 1'b0;
        #2;
        e         = blank(3'd3);
        e.mem_req = 1'b1;
        e.iord    = 1'b1;
        check("mem_wait", 32'(obs), 32'(e));
        rst_n = 1'b0;
        #1;
        check("rst_mid", 32'(obs), 32'h0);
`ifdef MCPU_CTRL_PERF_EN
        check("rst_mid instret", instret, 32'h0);
`endif
        exp_instret = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_instr("post_rst", 32'h002081B3, 0, 0, 1'b0);
        do_instr("post_rst_lw", 32'h0000A183, 1, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcpu_ctrl.md
Name: mcpu_ctrl

Overview:
- Multi-cycle RISC-V RV32I control unit; successor to the single-cycle decoder.
- Sequences FETCH/DECODE/EXEC/MEM/WB/TRAP over a shared datapath and handshakes with variable-latency memory.
- Memory waits are bounded by a timeout.
- Sits between the instruction register fields and the multi-cycle datapath/bus interface.

Parameters:
ALU_W, 5, width of alu_control (same opcode encoding as the single-cycle decoder's 5-bit field)
MEM_TIMEOUT, 15, max cycles waiting for mem_ready before bus-error trap (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
OPcode  in  7  IR[6:0]
Fun3  in  3  IR[14:12]
Fun12  in  12  IR[31:20]
mem_ready  in  1  memory completes current request this cycle
br_taken  in  1  datapath compare result, valid in EXEC
state  out  3  FSM state: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  store (valid with mem_req)
iord  out  1  address source: 0=PC, 1=ALUOut
ir_write  out  1  latch IR
pc_write  out  1  update PC
pc_src  out  2  0=PC+4, 1=ALUOut, 2=mtvec, 3=mepc
alu_src_a  out  2  0=PC, 1=rs1, 2=zero
alu_src_b  out  2  0=rs2, 1=imm, 2=const 4
alu_control  out  ALU_W  ALU operation
reg_write  out  1  write rd
mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC+4, 3=imm
trap  out  1  one-cycle trap pulse
trap_cause  out  2  0=illegal, 1=ecall/ebreak, 2=bus error, 3=mret

Behaviour:
- Reset (async, rst_n=0): state=FETCH; wait counter=0; all strobes (mem_req, mem_we, ir_write, pc_write, reg_write, trap) = 0; muxes and trap_cause = 0.
- Outputs are Moore (decoded from state + registered IR fields), except the pc_write gating noted below.
- FETCH: mem_req=1, iord=0.
  - On mem_ready: ir_write=1, pc_write=1 with pc_src=0; next DECODE.
- DECODE: alu_src_a=0, alu_src_b=1, ADD, producing the branch/jump target in ALUOut.
  - Instruction classification uses the same encoding set as the single-cycle decoder.
  - Unlisted encoding: next TRAP, cause 0.
  - ecall/ebreak: next TRAP, cause 1.
  - mret: next TRAP, cause 3.
  - Otherwise: next EXEC.
- EXEC, by class:
  - R-type: alu_src_a=1, alu_src_b=0, op from Fun3/Fun12; next WB.
  - I-ALU: alu_src_a=1, alu_src_b=1; next WB.
  - load/store: alu_src_a=1, alu_src_b=1, ADD; next MEM.
  - branch: compare op; pc_write=br_taken (combinational gate), pc_src=1; next FETCH.
  - jal: pc_write=1, pc_src=1, reg_write=1, mem_to_reg=2; next FETCH.
  - jalr: alu_src_a=1, alu_src_b=1, ADD; target LSB cleared by datapath; pc_write=1 and reg_write=1 occur in the same cycle using pre-update PC+4; next FETCH.
  - lui: reg_write=1, mem_to_reg=3; next FETCH.
  - auipc: alu_src_a=0, alu_src_b=1; next WB.
- MEM: mem_req=1, iord=1, mem_we=store.
  - On mem_ready: load goes to WB with mem_to_reg=1; store goes to FETCH.
- WB: reg_write=1, mem_to_reg per class; next FETCH.
- TRAP: trap=1 for exactly one cycle; pc_write=1.
  - pc_src=3 if cause 3, else 2.
  - Next FETCH.
- Wait counter, in FETCH/MEM only:
  - Cleared on state entry; increments each cycle mem_req is high and mem_ready low.
  - When the count reaches MEM_TIMEOUT without mem_ready: next TRAP, cause 2; the request is dropped (mem_req=0 in TRAP).
  - mem_ready in the same cycle the count hits MEM_TIMEOUT wins; no trap.
- mem_ready outside FETCH/MEM is ignored.
- Writes to rd=x0 are not suppressed here; the register file handles x0.
- Reset mid-request: immediate return to FETCH; mem_req drops asynchronously.

Optional Feature:
MCPU_CTRL_PERF_EN:
- Defined: adds output instret (32 bits), reset 0, incremented on every transition into FETCH from EXEC, MEM, or WB, i.e. one count per retired instruction; TRAP transitions do not count. Also adds output cycle_cnt (32 bits), incrementing every cycle out of reset. Both wrap at 2^32.
- Undefined: neither port exists; no counter logic.

Test Plan:
- add x3,x1,x2 with mem_ready one cycle after mem_req -> states 0,1,2,4,0; reg_write=1 only in WB; instret=1.
- lw with mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles with iord=1; WB has mem_to_reg=1.
- beq: br_taken=1 -> pc_write=1 with pc_src=1 in EXEC; br_taken=0 -> pc_write=0; both return to FETCH next cycle.
- Fetch with mem_ready never asserted, MEM_TIMEOUT=15 -> TRAP on the 16th cycle, trap=1, trap_cause=2, pc_src=2; mem_ready exactly on the 15th waiting cycle -> no trap.
- IR=0x00000000 -> TRAP cause 0. ecall (0x00000073) -> cause 1. mret (0x30200073) -> cause 3 with pc_src=3.
- rst_n low mid-MEM wait -> state=0 and all strobes 0 immediately; normal fetch resumes after release.
